id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage pipelined CPU, directly downstream of instruction fetch. It holds the IF/ID pipeline register and the 32×32 register file, and it detects load-use and branch-operand hazards. Branches and jumps resolve here, and the stage returns `pc_src`, `pc_target` and `stall` to the fetch stage. Decoded fields and operands go on to the ID/EX register.

## Interface
No parameters. Fixed widths: 32-bit data, 5-bit register index.
- `clk` in 1: single clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `if_inst` in 32: instruction fetched this cycle.
- `if_pc_plus4` in 32: PC+4 of `if_inst`.
- `wb_we` in 1, `wb_addr` in 5, `wb_data` in 32: writeback port.
- `ex_reg_write` in 1, `ex_mem_read` in 1, `ex_dst` in 5: EX-stage destination info.
- `mem_reg_write` in 1, `mem_mem_read` in 1, `mem_dst` in 5, `mem_alu_result` in 32: MEM-stage destination info and ALU result.
- `stall` out 1: hold PC and IF/ID; ID/EX inserts a bubble.
- `pc_src` out 2: 00 sequential, 01 branch taken, 10 j/jal, 11 jr.
- `pc_target` out 32: next-PC when `pc_src`≠00.
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_pc_plus4` out 32, `id_inst` out 32: latched values.
- `rs` out 5, `rt` out 5, `rd` out 5: inst[25:21], [20:16], [15:11].
- `rs_data` out 32, `rt_data` out 32: register-file reads, with WB bypass.
- `imm_ext` out 32: extended immediate.

## Operation
- IF/ID register update, in priority order: reset > stall > redirect > load.
  - reset: `id_inst`=0, `id_pc_plus4`=0, `id_valid`=0.
  - `stall`: hold all three.
  - redirect (`pc_src`≠00): load `id_inst`=0 and `id_valid`=0. This squashes the wrong-path fetch; there are no delay slots.
  - otherwise: load `if_inst`, `if_pc_plus4`, `id_valid`=1.
- Register file:
  - Reset clears all 32 entries.
  - Write occurs on posedge when `wb_we` && `wb_addr`≠0.
  - Reads are combinational. When `wb_we` && `wb_addr`≠0 && `wb_addr` equals the read index, the read returns `wb_data` (write-first).
  - r0 always reads 0.
- Decode by opcode inst[31:26]:
  - 00: R-type; with funct 08 it is jr.
  - 02: j. 03: jal.
  - 04: beq. 05: bne.
  - 23: lw. 2b: sw.
  - Other opcodes: I-type.
- `imm_ext`: zero-extend inst[15:0] for opcodes 0c, 0d, 0e; sign-extend otherwise.
- uses_rt: R-type, beq, bne, sw.
- Hazard terms:
  - needs(x) = x≠0 && (x==`rs` || (uses_rt && x==`rt`)).
  - is_ctl = beq, bne or jr.
- `stall`=1 only when `id_valid` and one of:
  - (a) `ex_mem_read` && needs(`ex_dst`) (load-use);
  - (b) is_ctl && `ex_reg_write` && needs(`ex_dst`);
  - (c) is_ctl && `mem_mem_read` && needs(`mem_dst`).
- Compare operand for branches and jr: use `mem_alu_result` when `mem_reg_write` && !`mem_mem_read` && `mem_dst`≠0 && `mem_dst`==index; otherwise use `rs_data`/`rt_data`.
- `pc_src` / `pc_target`:
  - Forced to 00 when `stall` or !`id_valid`.
  - beq taken when operands are equal; bne taken when they differ. Taken gives 01 with target `id_pc_plus4` + (sext(imm)<<2), mod 2^32.
  - j/jal: 10, target {`id_pc_plus4`[31:28], inst[25:0], 2'b00}.
  - jr: 11, target = forwarded rs operand.
  - `pc_target`=0 when `pc_src`=00.

## Timing
- All outputs other than IF/ID state are combinational from IF/ID plus the inputs. There is zero added latency within ID.
- Redirect: target fetched on the next cycle; exactly one wrong-path instruction is squashed.
- Load-use: exactly one stall cycle (load moves EX→MEM).
- Branch dependent on an EX ALU result: one stall cycle, then MEM forwarding.
- Branch dependent on a load in EX: two stall cycles.
- Reset asserted mid-stream: at the next edge, IF/ID and the register file clear. During reset, outputs reflect the cleared state: `stall`=0, `pc_src`=00, `id_valid`=0.
- Write to rN at cycle T with a read of rN at cycle T: the read returns the new data (bypass).

## Test plan
- Reset, then `if_inst`=0x2001_0005 (addi r1,r0,5), `if_pc_plus4`=4 → next cycle `id_valid`=1, `rs`=0, `rt`=1, `imm_ext`=5, `pc_src`=00, `stall`=0.
- Set r2=r3=7 via WB; fetch beq r2,r3,+3 at pc_plus4=0x10 → `pc_src`=01, `pc_target`=0x1C; next cycle `id_valid`=0, `id_inst`=0.
- `ex_mem_read`=1, `ex_dst`=4; ID holds add r5,r4,r6 → `stall`=1, IF/ID unchanged, `pc_src`=00; when `ex_mem_read` drops, the next edge loads the new `if_inst`.
- jr r31 with `mem_reg_write`=1, `mem_mem_read`=0, `mem_dst`=31, `mem_alu_result`=0x400 → `pc_src`=11, `pc_target`=0x400.
- WB writes r8=0xDEAD_BEEF while ID reads r8 in the same cycle → `rs_data`=0xDEADBEEF. WB to r0 → r0 still reads 0.
- ori with imm 0xFFFF → `imm_ext`=0x0000FFFF; lw with imm 0xFFFC → `imm_ext`=0xFFFFFFFC. j 0x100 at pc_plus4=0x8000_0004 → `pc_target`=0x8000_0400.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32x32 register file, hazard detection and early branch/jump resolution.
// Zero added latency: control outputs are combinational from IF/ID; stall holds IF/ID and bubbles ID/EX.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc_plus4,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dst,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_dst,
  input  logic [31:0] mem_alu_result,
  output logic        stall,
  output logic [1:0]  pc_src,
  output logic [31:0] pc_target,
  output logic        id_valid,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_inst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext
);
  logic [31:0] regs [32];
  logic [5:0]  op, funct;
  logic        is_rtype, is_jr, is_j, is_beq, is_bne, is_sw, uses_rt, is_ctl;
  logic        ex_needs, mem_needs, mem_fwd_ok;
  logic        wb_live;
  logic [31:0] op_a, op_b, br_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Redirect squashes the wrong-path fetch; id_pc_plus4 is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_inst     <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (!stall) begin
      if (pc_src != 2'b00) begin
        id_inst  <= '0;
        id_valid <= 1'b0;
      end else begin
        id_inst     <= if_inst;
        id_pc_plus4 <= if_pc_plus4;
        id_valid    <= 1'b1;
      end
    end
  end

  assign op    = id_inst[31:26];
  assign funct = id_inst[5:0];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign rd    = id_inst[15:11];

  assign is_rtype = (op == 6'h00);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_j     = (op == 6'h02) || (op == 6'h03);
  assign is_beq   = (op == 6'h04);
  assign is_bne   = (op == 6'h05);
  assign is_sw    = (op == 6'h2b);
  assign uses_rt  = is_rtype || is_beq || is_bne || is_sw;
  assign is_ctl   = is_beq || is_bne || is_jr;

  // Write-first read: a same-cycle writeback is visible to decode.
  assign wb_live = wb_we && (wb_addr != 5'd0);
  assign rs_data = (rs == 5'd0) ? 32'd0 : (wb_live && wb_addr == rs) ? wb_data : regs[rs];
  assign rt_data = (rt == 5'd0) ? 32'd0 : (wb_live && wb_addr == rt) ? wb_data : regs[rt];

  assign imm_ext = (op == 6'h0c || op == 6'h0d || op == 6'h0e) ? {16'd0, id_inst[15:0]}
                                                              : {{16{id_inst[15]}}, id_inst[15:0]};

  assign ex_needs  = (ex_dst != 5'd0) && ((ex_dst == rs) || (uses_rt && ex_dst == rt));
  assign mem_needs = (mem_dst != 5'd0) && ((mem_dst == rs) || (uses_rt && mem_dst == rt));

  assign stall = id_valid && ((ex_mem_read && ex_needs) ||
                              (is_ctl && ex_reg_write && ex_needs) ||
                              (is_ctl && mem_mem_read && mem_needs));

  // Only a MEM-stage ALU result is forwardable; loads have not returned data yet.
  assign mem_fwd_ok = mem_reg_write && !mem_mem_read && (mem_dst != 5'd0);
  assign op_a       = (mem_fwd_ok && mem_dst == rs) ? mem_alu_result : rs_data;
  assign op_b       = (mem_fwd_ok && mem_dst == rt) ? mem_alu_result : rt_data;
  assign br_off     = {{14{id_inst[15]}}, id_inst[15:0], 2'b00};

  always_comb begin
    pc_src    = 2'b00;
    pc_target = 32'd0;
    if (id_valid && !stall) begin
      if ((is_beq && op_a == op_b) || (is_bne && op_a != op_b)) begin
        pc_src    = 2'b01;
        pc_target = id_pc_plus4 + br_off;
      end else if (is_j) begin
        pc_src    = 2'b10;
        pc_target = {id_pc_plus4[31:28], id_inst[25:0], 2'b00};
      end else if (is_jr) begin
        pc_src    = 2'b11;
        pc_target = op_a;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage: behavioural model of decode, register file and hazards, plus directed checks.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_inst = '0, if_pc_plus4 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0;
  logic [4:0]  ex_dst = '0;
  logic        mem_reg_write = 1'b0, mem_mem_read = 1'b0;
  logic [4:0]  mem_dst = '0;
  logic [31:0] mem_alu_result = '0;
  logic        stall, id_valid;
  logic [1:0]  pc_src;
  logic [31:0] pc_target, id_pc_plus4, id_inst, rs_data, rt_data, imm_ext;
  logic [4:0]  rs, rt, rd;

  id_stage dut (
    .clk(clk), .reset(reset), .if_inst(if_inst), .if_pc_plus4(if_pc_plus4),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .mem_alu_result(mem_alu_result), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst),
    .rs(rs), .rt(rt), .rd(rd), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  bit [31:0] m_regs [32];
  bit [31:0] m_inst, m_pc4;
  bit        m_valid;

  typedef struct {
    bit        stall;
    bit [1:0]  pc_src;
    bit [31:0] target, rs_data, rt_data, imm;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] reg_read(input bit [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_we && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit depends(input bit [4:0] x, input bit [4:0] a, input bit [4:0] b, input bit use_b);
    return x != 0 && (x == a || (use_b && x == b));
  endfunction

  // What decode must produce from the model's IF/ID contents and the present inputs.
  function automatic exp_t predict();
    exp_t e;
    bit [5:0]  op = m_inst[31:26];
    bit [4:0]  a = m_inst[25:21], b = m_inst[20:16];
    bit        beq = (op == 6'h04), bne = (op == 6'h05), jmp = (op == 6'h02 || op == 6'h03);
    bit        jr = (op == 6'h00 && m_inst[5:0] == 6'h08);
    bit        use_b = (op == 6'h00) || beq || bne || (op == 6'h2b);
    bit        ctl = beq || bne || jr;
    bit [31:0] va, vb;
    int        off;
    e.rs_data = reg_read(a);
    e.rt_data = reg_read(b);
    if (op == 6'h0c || op == 6'h0d || op == 6'h0e) e.imm = {16'd0, m_inst[15:0]};
    else e.imm = 32'($signed(m_inst[15:0]));
    e.stall = m_valid && ((ex_mem_read && depends(ex_dst, a, b, use_b)) ||
                          (ctl && ex_reg_write && depends(ex_dst, a, b, use_b)) ||
                          (ctl && mem_mem_read && depends(mem_dst, a, b, use_b)));
    va = (mem_reg_write && !mem_mem_read && mem_dst != 0 && mem_dst == a) ? mem_alu_result : e.rs_data;
    vb = (mem_reg_write && !mem_mem_read && mem_dst != 0 && mem_dst == b) ? mem_alu_result : e.rt_data;
    e.pc_src = 2'b00;
    e.target = 32'd0;
    if (m_valid && !e.stall) begin
      off = 4 * int'($signed(m_inst[15:0]));
      if ((beq && va == vb) || (bne && va != vb)) begin
        e.pc_src = 2'b01;
        e.target = m_pc4 + 32'(off);
      end else if (jmp) begin
        e.pc_src = 2'b10;
        e.target = (m_pc4 & 32'hF000_0000) | (32'(m_inst[25:0]) * 4);
      end else if (jr) begin
        e.pc_src = 2'b11;
        e.target = va;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_inst = 0; m_pc4 = 0; m_valid = 0;
    end else begin
      e = predict();
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (!e.stall) begin
        if (e.pc_src != 0) begin
          m_inst = 0; m_valid = 0;
        end else begin
          m_inst = if_inst; m_pc4 = if_pc_plus4; m_valid = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = predict();
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      chk("id_inst", id_inst, m_inst);
      if (m_valid) chk("id_pc_plus4", id_pc_plus4, m_pc4);
      chk("rs", {27'd0, rs}, {27'd0, m_inst[25:21]});
      chk("rt", {27'd0, rt}, {27'd0, m_inst[20:16]});
      chk("rd", {27'd0, rd}, {27'd0, m_inst[15:11]});
      chk("rs_data", rs_data, e.rs_data);
      chk("rt_data", rt_data, e.rt_data);
      chk("imm_ext", imm_ext, e.imm);
      chk("stall", {31'd0, stall}, {31'd0, e.stall});
      chk("pc_src", {30'd0, pc_src}, {30'd0, e.pc_src});
      chk("pc_target", pc_target, e.target);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [4:0] pick_reg();
    int r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic bit [31:0] rand_inst();
    bit [4:0]  a = pick_reg(), b = pick_reg(), d = pick_reg();
    bit [15:0] imm = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 8));
    case ($urandom_range(0, 13))
      0, 1:    return {6'h00, a, b, d, 5'd0, 6'h20};
      2:       return {6'h00, a, 15'd0, 6'h08};
      3:       return {6'h02, 26'($urandom)};
      4:       return {6'h03, 26'($urandom)};
      5, 6:    return {6'h04, a, b, imm};
      7, 8:    return {6'h05, a, b, imm};
      9:       return {6'h23, a, b, imm};
      10:      return {6'h2b, a, b, imm};
      11:      return {6'h08, a, b, imm};
      12:      return {6'h0d, a, b, imm};
      default: return {6'($urandom_range(6'h0c, 6'h0f)), a, b, imm};
    endcase
  endfunction

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset id_valid", {31'd0, id_valid}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset pc_src", {30'd0, pc_src}, 32'd0);
    chk("reset id_inst", id_inst, 32'd0);
    reset = 1'b0;

    if_inst = 32'h2001_0005; if_pc_plus4 = 32'd4;
    tick();
    if_inst = 32'd0; if_pc_plus4 = 32'd8;
    #1;
    chk("addi valid", {31'd0, id_valid}, 32'd1);
    chk("addi rs", {27'd0, rs}, 32'd0);
    chk("addi rt", {27'd0, rt}, 32'd1);
    chk("addi imm", imm_ext, 32'd5);
    chk("addi pc_src", {30'd0, pc_src}, 32'd0);
    chk("addi stall", {31'd0, stall}, 32'd0);

    wb_we = 1; wb_addr = 2; wb_data = 7;
    tick();
    wb_addr = 3;
    tick();
    wb_we = 0; if_inst = 32'h1043_0003; if_pc_plus4 = 32'h10;
    tick();
    if_inst = 32'h2009_0009; if_pc_plus4 = 32'h14;
    #1;
    chk("beq pc_src", {30'd0, pc_src}, 32'd1);
    chk("beq target", pc_target, 32'h1C);
    tick();
    #1;
    chk("squash valid", {31'd0, id_valid}, 32'd0);
    chk("squash inst", id_inst, 32'd0);

    if_inst = 32'h0086_2820; if_pc_plus4 = 32'h20;
    tick();
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 4; if_inst = 32'h2009_0001; if_pc_plus4 = 32'h24;
    #1;
    chk("loaduse stall", {31'd0, stall}, 32'd1);
    chk("loaduse pc_src", {30'd0, pc_src}, 32'd0);
    tick();
    #1;
    chk("loaduse hold", id_inst, 32'h0086_2820);
    ex_mem_read = 0; ex_reg_write = 0;
    #1;
    chk("loaduse release", {31'd0, stall}, 32'd0);
    tick();
    #1;
    chk("loaduse next", id_inst, 32'h2009_0001);

    if_inst = 32'h03E0_0008; if_pc_plus4 = 32'h28;
    tick();
    mem_reg_write = 1; mem_dst = 31; mem_alu_result = 32'h400; if_inst = 32'h2009_0002;
    #1;
    chk("jr pc_src", {30'd0, pc_src}, 32'd3);
    chk("jr target", pc_target, 32'h400);
    tick();
    mem_reg_write = 0; mem_dst = 0; mem_alu_result = 0;

    if_inst = 32'h2101_0000; if_pc_plus4 = 32'h404;
    tick();
    wb_we = 1; wb_addr = 8; wb_data = 32'hDEAD_BEEF; if_inst = 32'h2000_0000;
    #1;
    chk("wb bypass r8", rs_data, 32'hDEAD_BEEF);
    tick();
    wb_addr = 0; wb_data = 32'h55;
    #1;
    chk("r0 during wb", rs_data, 32'd0);
    tick();
    wb_we = 0;
    #1;
    chk("r0 after wb", rs_data, 32'd0);

    if_inst = 32'h3400_FFFF;
    tick();
    if_inst = 32'h8C00_FFFC;
    #1;
    chk("ori imm", imm_ext, 32'h0000_FFFF);
    tick();
    if_inst = 32'h0800_0100; if_pc_plus4 = 32'h8000_0004;
    #1;
    chk("lw imm", imm_ext, 32'hFFFF_FFFC);
    tick();
    if_inst = 32'd0;
    #1;
    chk("j pc_src", {30'd0, pc_src}, 32'd2);
    chk("j target", pc_target, 32'h8000_0400);
    tick();

    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 59) == 0);
      if_inst        = rand_inst();
      if_pc_plus4    = $urandom & 32'hFFFF_FFFC;
      wb_we          = ($urandom % 2 == 0);
      wb_addr        = pick_reg();
      wb_data        = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 3));
      ex_mem_read    = ($urandom % 4 == 0);
      ex_reg_write   = ex_mem_read || ($urandom % 2 == 0);
      ex_dst         = pick_reg();
      mem_mem_read   = ($urandom % 4 == 0);
      mem_reg_write  = mem_mem_read || ($urandom % 2 == 0);
      mem_dst        = pick_reg();
      mem_alu_result = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 3));
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
